grid_loader: RTL

Front-end stage that fills the shared grid RAM from a byte stream of puzzle text before the day-04 solver runs. It accepts ASCII rows over a valid/ready stream and strips line terminators. Cells are packed row-major from address 0 with no gaps, and an EOT byte (0x04) is written directly after the last row. `Done` releases the solver; `Error` flags malformed input.

---
 rtl/grid_loader_pkg.sv | 43 ++++
 rtl/grid_loader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/grid_loader_pkg.sv
// Shared constants and types for the grid RAM front end: address type, RAM size,
// ASCII codes seen in puzzle text, and the loader's state/register layout.
package grid_loader_pkg;

    localparam int unsigned RAM_DEPTH  = 20480;
    localparam int unsigned RAM_ADDR_W = 15;

    typedef logic [RAM_ADDR_W-1:0] RamAddr_t;

    localparam logic [7:0] ASCII_DOT = 8'h2E;
    localparam logic [7:0] ASCII_AT  = 8'h40;
    localparam logic [7:0] ASCII_EOT = 8'h04;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;

    typedef enum logic [1:0] {
        S_LOAD,
        S_EOT,
        S_DONE,
        S_ERROR
    } loader_state_e;

    typedef struct packed {
        loader_state_e state;
        RamAddr_t      ptr;        // next free cell address
        logic [15:0]   column;
        logic [15:0]   row_count;
        logic          in_ready;
        RamAddr_t      wr_addr;
        logic          wr_en;
        logic [7:0]    wr_data;
        logic          done;
        logic          error;
    } loader_regs_t;

    // True when one more full row still leaves a slot for the trailing EOT byte.
    function automatic logic row_fits(input logic [15:0] rows_done, input int unsigned cols);
        int unsigned need;
        need = (32'(rows_done) + 32'd1) * cols + 32'd1;
        return need <= RAM_DEPTH;
    endfunction

endpackage

// File: rtl/grid_loader.sv
// Streams ASCII puzzle rows into the grid RAM row-major, strips CR/LF, appends EOT,
// then raises Done; malformed input or a full RAM raises Error instead.
module grid_loader
    import grid_loader_pkg::*;
#(
    parameter int GRID_COLUMNS = 138
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [7:0]  InData,
    input  logic        InLast,
    output RamAddr_t    WriteAddr,
    output logic        WriteEnable,
    output logic [7:0]  WriteData,
    output logic [15:0] RowCount,
    output logic        Done,
    output logic        Error
);

    localparam logic [15:0] COLS = 16'(GRID_COLUMNS);

    localparam loader_regs_t REGS_RESET = '{
        state:     S_LOAD,
        ptr:       '0,
        column:    '0,
        row_count: '0,
        in_ready:  1'b1,
        wr_addr:   '0,
        wr_en:     1'b0,
        wr_data:   '0,
        done:      1'b0,
        error:     1'b0
    };

    loader_regs_t regs_q, regs_d;

    logic        accept;
    logic        is_cell;
    logic        row_done;
    logic        bad;
    logic [15:0] col_next;
    logic [15:0] rows_next;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        regs_d       = regs_q;
        regs_d.wr_en = 1'b0;
        accept       = InValid && regs_q.in_ready;
        is_cell      = (InData == ASCII_DOT) || (InData == ASCII_AT);
        col_next     = regs_q.column;
        rows_next    = regs_q.row_count;
        row_done     = 1'b0;
        bad          = 1'b0;

        unique case (regs_q.state)
            S_LOAD: begin
                if (accept) begin
                    if (is_cell) begin
                        if (regs_q.column < COLS) begin
                            regs_d.wr_en   = 1'b1;
                            regs_d.wr_addr = regs_q.ptr;
                            regs_d.wr_data = InData;
                            regs_d.ptr     = regs_q.ptr + 1'b1;
                            col_next       = regs_q.column + 16'd1;
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (InData == ASCII_LF) begin
                        if (regs_q.column == COLS) row_done = 1'b1;
                        else                       bad      = 1'b1;
                    end else if (InData != ASCII_CR) begin
                        bad = 1'b1;
                    end

                    // A final row without a trailing LF completes on the last byte.
                    if (!bad && InLast && (col_next == COLS)) row_done = 1'b1;

                    if (row_done) begin
                        col_next = '0;
                        if (row_fits(regs_q.row_count, GRID_COLUMNS))
                            rows_next = (regs_q.row_count == 16'hFFFF) ? regs_q.row_count
                                                                        : regs_q.row_count + 16'd1;
                        else
                            bad = 1'b1;
                    end

                    if (bad) begin
                        regs_d.state    = S_ERROR;
                        regs_d.in_ready = 1'b0;
                        regs_d.error    = 1'b1;
                        regs_d.wr_en    = 1'b0;
                    end else begin
                        regs_d.column    = col_next;
                        regs_d.row_count = rows_next;
                        if (InLast) begin
                            regs_d.in_ready = 1'b0;
                            if ((col_next == '0) && (rows_next != '0)) begin
                                regs_d.state = S_EOT;
                            end else begin
                                regs_d.state = S_ERROR;
                                regs_d.error = 1'b1;
                            end
                        end
                    end
                end
            end
            S_EOT: begin
                regs_d.wr_en   = 1'b1;
                regs_d.wr_addr = regs_q.ptr;
                regs_d.wr_data = ASCII_EOT;
                regs_d.state   = S_DONE;
            end
            S_DONE: begin
                regs_d.done = 1'b1;
            end
            S_ERROR: begin
                regs_d.error = 1'b1;
            end
            default: begin
                regs_d = REGS_RESET;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge value of regs_d.
    always_ff @(posedge Clk) begin
        if (Reset) regs_q <= REGS_RESET;
        else       regs_q <= regs_d;
    end

    assign InReady     = regs_q.in_ready;
    assign WriteAddr   = regs_q.wr_addr;
    assign WriteEnable = regs_q.wr_en;
    assign WriteData   = regs_q.wr_data;
    assign RowCount    = regs_q.row_count;
    assign Done        = regs_q.done;
    assign Error       = regs_q.error;

endmodule
